rv_encoder: RTL and testbench
=============================

# rv_encoder

Streaming RV32I instruction encoder, the inverse of the instruction decoder. It accepts an operation code in the packed `RV32_INSTRUCTION` layout plus register and immediate fields over a valid/ready handshake. It assembles the 32-bit instruction word and emits it with a sequential instruction-memory address on a registered valid/ready output. It sits between the debug/boot-loader command path and the instruction-memory write port.

## Interface
- `ADDR_W`, 12, width of the byte address counter (word-aligned, wraps at 2^ADDR_W).
- `RESET_ADDR`, 0, address counter value after reset; must be a multiple of 4.
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `req_valid` input 1: request present.
- `req_ready` output 1: request accepted when `req_valid && req_ready`.
- `req_op` input 9: `{instr[30], funct3, opcode[6:2]}` (`RV32_INSTRUCTION` packing).
- `req_rd`, `req_rs1`, `req_rs2` input 5 each: register indices.
- `req_imm` input 32: full-value immediate (byte offset for B/J, full upper value for U).
- `addr_load` input 1: load address counter from `addr_base`.
- `addr_base` input ADDR_W: new base address, bits [1:0] ignored.
- `out_valid` output 1: encoded word available.
- `out_ready` input 1: consumer takes the word when `out_valid && out_ready`.
- `out_instr` output 32: encoded instruction.
- `out_addr` output ADDR_W: byte address for `out_instr`.
- `word_count` output 16: words emitted since reset, saturating at 0xFFFF.
- `err` output 1: sticky encode error (see Configuration).
- `err_clr` input 1: clears `err`.

## Operation
- Format class from `req_op[4:0]`:
  - I: 00000, 00001, 00100, 00110, 11001.
  - R: 01011, 01100, 01110, 10100.
  - U: 00101, 01101.
  - S: 01000, 01001.
  - B: 11000.
  - J: 11011.
  - Any other value is an unknown class.
- Opcode field: `instr[6:0] = {req_op[4:0], 2'b11}`. Funct3 field: `instr[14:12] = req_op[7:5]` for I/R/S/B; U/J place immediate bits there.
- R: funct7 = `{1'b0, req_op[8], 5'b0}`; rd/rs1/rs2 from request.
- I: `imm[11:0]` in [31:20]. Shift-immediates (opcode 00100, funct3 001/101): [31:25] = `{1'b0, req_op[8], 5'b0}`, [24:20] = `imm[4:0]`.
- S: `{imm[11:5], rs2, rs1, f3, imm[4:0], opc}`.
- B: `{imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc}`.
- U: `{imm[31:12], rd, opc}`.
- J: `{imm[20], imm[10:1], imm[11], imm[19:12], rd, opc}`.
- Register fields unused by a format are encoded as zero.
- Unknown class: word is all zeros and is still emitted. With the range check compiled in, it is treated as an error instead (see Configuration).
- Address counter `addr`:
  - Each accepted request captures `out_addr = addr`; `addr` then advances by 4, modulo 2^ADDR_W.
  - `addr_load` without an accept: `addr <= addr_base & ~3`.
  - `addr_load` in the same cycle as an accept: the accepted word takes `addr_base & ~3` and `addr` becomes that value + 4. Load has priority over the counter value.
- `word_count` increments on each output handshake and saturates at 0xFFFF.

## Timing
- Reset values: `out_valid` = 0, `out_instr` = 0, `out_addr` = `RESET_ADDR`, `addr` = `RESET_ADDR`, `word_count` = 0, `err` = 0.
- The output register is one stage: `req_ready = !out_valid || out_ready`, combinational and with no other dependency.
- Latency: a request accepted at edge N produces `out_valid` = 1 with its word after edge N. Throughput is 1 word per cycle under continuous `out_ready`.
- While `out_valid && !out_ready`, `out_instr` and `out_addr` hold stable and `req_ready` = 0.
- Simultaneous output handshake and new accept: the output register reloads with the new word and `out_valid` stays 1.
- Reset asserted mid-stream: any pending word is discarded immediately and the counter returns to `RESET_ADDR`.
- `err_clr` in the same cycle as a new error: the error wins and `err` = 1.

## Configuration
- `RV_ENCODER_RANGE_CHECK_EN` defined:
  - Each accepted request is checked for these errors:
    - I/S immediate not the sign-extension of 12 bits.
    - Shift amount with `imm[31:5]` ≠ 0.
    - B immediate outside 13-bit signed range, or `imm[0]` = 1.
    - J immediate outside 21-bit signed range, or `imm[0]` = 1.
    - U with `imm[11:0]` ≠ 0.
    - Unknown class.
  - An offending request is consumed but not emitted: `addr` and `word_count` are unchanged and `err` sets on the next edge.
- Macro undefined: no checks are made, immediate bits are truncated per format, and `err` is tied to 0.

## Test plan
- ADDI (op 9'h004) rd=1, rs1=0, imm=5 → `out_instr` = 0x00500093, `out_addr` = 0x000 one cycle after accept.
- ADD/SUB rd=3, rs1=1, rs2=2, back-to-back with `req_op[8]` = 0 then 1 → 0x002081B3 then 0x402081B3 at addresses 0x000 and 0x004, with no bubble.
- LUI rd=5, imm=0x12345000 → 0x123452B7. BEQ rs1=1, rs2=2, imm=8 → 0x00208463. JAL rd=1, imm=0x800 → 0x001000EF. SRAI rd=1, rs1=1, shamt=3, `req_op[8]` = 1 → 0x4030D093.
- Hold `out_ready` = 0 for 3 cycles with `req_valid` = 1:
  - The first word stays stable and `req_ready` = 0.
  - Once `out_ready` is released, the remaining words arrive in order with consecutive addresses.
  - Counter at 0xFFC wraps to 0x000.
- `addr_load` with `addr_base` = 0x103 in the same cycle as an accept → `out_addr` = 0x100, and the next word is at 0x104.
- With `RV_ENCODER_RANGE_CHECK_EN`: ADDI imm=0x800 → nothing emitted, `err` = 1, `word_count` unchanged. `err_clr` → `err` = 0. `rst_n` low mid-stream → `out_valid` = 0 at once.

Source files
------------

// File: rtl/rv_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : rv_encoder_if
// Description : Request and output handshake bundle for rv_encoder.
//               master = command source / instruction-memory writer side,
//               slave  = the encoder itself.
// Signals     : req_valid/req_ready, req_op[8:0], req_rd/rs1/rs2[4:0],
//               req_imm[31:0], out_valid/out_ready, out_instr[31:0],
//               out_addr[ADDR_W-1:0]
// Revision    : 1.0 - initial release
// ============================================================================
interface rv_encoder_if #(
  parameter int unsigned ADDR_W = 12
) ();
  logic              req_valid;
  logic              req_ready;
  logic [8:0]        req_op;
  logic [4:0]        req_rd;
  logic [4:0]        req_rs1;
  logic [4:0]        req_rs2;
  logic [31:0]       req_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm, out_ready,
    input  req_ready, out_valid, out_instr, out_addr
  );

  modport slave (
    input  req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm, out_ready,
    output req_ready, out_valid, out_instr, out_addr
  );
endinterface
`default_nettype wire

// File: rtl/rv_encoder.sv
`default_nettype none
// ============================================================================
// Module      : rv_encoder
// Description : Streaming RV32I instruction encoder. Assembles a 32-bit
//               instruction word from a packed op code plus register and
//               immediate fields and emits it with a sequential word-aligned
//               instruction-memory byte address through a one-stage
//               registered valid/ready output.
// Ports       : clk, rst_n (async, active-low)
//               bus        : rv_encoder_if.slave (request + output handshake)
//               addr_load  : load address counter from addr_base
//               addr_base  : new base address (bits [1:0] ignored)
//               word_count : words emitted since reset, saturating
//               err        : sticky encode error, err_clr clears it
// Option      : RV_ENCODER_RANGE_CHECK_EN - reject requests whose immediate
//               does not fit the format (or unknown op class); otherwise
//               immediates are truncated and err is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_encoder #(
  parameter int unsigned       ADDR_W     = 12,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  rv_encoder_if.slave       bus,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_base,
  output logic [15:0]       word_count,
  output logic              err,
  input  logic              err_clr
);

  typedef enum logic [2:0] {
    CLS_I = 3'd0,
    CLS_R = 3'd1,
    CLS_U = 3'd2,
    CLS_S = 3'd3,
    CLS_B = 3'd4,
    CLS_J = 3'd5,
    CLS_X = 3'd6
  } fmt_cls_e;

  fmt_cls_e          cls;
  logic [2:0]        f3;
  logic [6:0]        opc;
  logic [6:0]        f7;
  logic              is_shift;
  logic [31:0]       imm;
  logic [31:0]       enc_word;
  logic              bad_req;
  logic              accept;
  logic              emit;
  logic              out_hs;
  logic [ADDR_W-1:0] base_addr;

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [15:0]       cnt_q,       cnt_d;

  assign imm      = bus.req_imm;
  assign f3       = bus.req_op[7:5];
  assign opc      = {bus.req_op[4:0], 2'b11};
  assign f7       = {1'b0, bus.req_op[8], 5'b0};
  // SLLI/SRLI/SRAI share OP-IMM with the other I ops; funct3 x01 marks them.
  assign is_shift = (bus.req_op[4:0] == 5'b00100) && (f3[1:0] == 2'b01);

  always_comb begin
    cls = CLS_X;
    case (bus.req_op[4:0])
      5'b00000, 5'b00001, 5'b00100, 5'b00110, 5'b11001: cls = CLS_I;
      5'b01011, 5'b01100, 5'b01110, 5'b10100:           cls = CLS_R;
      5'b00101, 5'b01101:                               cls = CLS_U;
      5'b01000, 5'b01001:                               cls = CLS_S;
      5'b11000:                                         cls = CLS_B;
      5'b11011:                                         cls = CLS_J;
      default:                                          cls = CLS_X;
    endcase
  end

  always_comb begin
    enc_word = '0;
    case (cls)
      CLS_R: enc_word = {f7, bus.req_rs2, bus.req_rs1, f3, bus.req_rd, opc};
      CLS_I: begin
        if (is_shift) enc_word = {f7, imm[4:0], bus.req_rs1, f3, bus.req_rd, opc};
        else          enc_word = {imm[11:0], bus.req_rs1, f3, bus.req_rd, opc};
      end
      CLS_S: enc_word = {imm[11:5], bus.req_rs2, bus.req_rs1, f3, imm[4:0], opc};
      CLS_B: enc_word = {imm[12], imm[10:5], bus.req_rs2, bus.req_rs1, f3,
                         imm[4:1], imm[11], opc};
      CLS_U: enc_word = {imm[31:12], bus.req_rd, opc};
      CLS_J: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.req_rd, opc};
      default: enc_word = '0;
    endcase
  end

`ifdef RV_ENCODER_RANGE_CHECK_EN
  logic err_q, err_d;

  // A signed N-bit value in 32 bits has bits [31:N-1] all equal.
  always_comb begin
    bad_req = 1'b0;
    case (cls)
      CLS_I: begin
        if (is_shift) bad_req = (imm[31:5] != '0);
        else          bad_req = !((imm[31:11] == '0) || (imm[31:11] == '1));
      end
      CLS_S: bad_req = !((imm[31:11] == '0) || (imm[31:11] == '1));
      CLS_B: bad_req = !((imm[31:12] == '0) || (imm[31:12] == '1)) || imm[0];
      CLS_J: bad_req = !((imm[31:20] == '0) || (imm[31:20] == '1)) || imm[0];
      CLS_U: bad_req = (imm[11:0] != '0);
      CLS_R: bad_req = 1'b0;
      default: bad_req = 1'b1;
    endcase
  end

  // A new error outranks a clear in the same cycle.
  always_comb begin
    err_d = err_q;
    if (err_clr)           err_d = 1'b0;
    if (accept && bad_req) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign bad_req        = 1'b0;
  assign err            = 1'b0;
`endif

  assign bus.req_ready = !out_valid_q || bus.out_ready;
  assign accept        = bus.req_valid && bus.req_ready;
  assign emit          = accept && !bad_req;
  assign out_hs        = out_valid_q && bus.out_ready;
  // A load in the accept cycle addresses the accepted word itself.
  assign base_addr     = addr_load ? {addr_base[ADDR_W-1:2], 2'b00} : addr_q;

  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_addr_d  = out_addr_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    if (out_hs) out_valid_d = 1'b0;
    if (emit) begin
      out_valid_d = 1'b1;
      out_instr_d = enc_word;
      out_addr_d  = base_addr;
      addr_d      = base_addr + ADDR_W'(4);
    end else if (addr_load) begin
      addr_d      = base_addr;
    end
    if (out_hs && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= RESET_ADDR;
      addr_q      <= RESET_ADDR;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_addr  = out_addr_q;
  assign word_count    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rv_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_encoder
// Description : Self-checking bench for rv_encoder. Expected words and
//               addresses are queued when a request is driven and compared
//               by a monitor whenever the output handshakes. Build with
//               RV_ENCODER_RANGE_CHECK_EN to exercise the error path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_encoder;
  localparam int unsigned ADDR_W = 12;

  typedef struct packed {
    logic [31:0] instr;
    logic [11:0] addr;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        addr_load;
  logic [11:0] addr_base;
  logic [15:0] word_count;
  logic        err;
  logic        err_clr;

  sb_t         sb_q[$];
  logic [11:0] next_addr;
  logic [15:0] hs_model;
  int          chk_total;
  int          chk_pass;
  int          cyc;

  rv_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  rv_encoder #(.ADDR_W(ADDR_W), .RESET_ADDR(12'h000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .addr_load  (addr_load),
    .addr_base  (addr_base),
    .word_count (word_count),
    .err        (err),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: samples mid-low-phase, after the drivers settle.
  always @(negedge clk) begin
    sb_t exp_e;
    #2;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      chk_total++;
      if (sb_q.size() == 0) begin
        $display("FAIL sb_unexpected: got instr=%h addr=%h, required none", bus.out_instr, bus.out_addr);
      end else begin
        exp_e = sb_q.pop_front();
        if (bus.out_instr !== exp_e.instr || bus.out_addr !== exp_e.addr)
          $display("FAIL sb_word: got instr=%h addr=%h, required instr=%h addr=%h",
                   bus.out_instr, bus.out_addr, exp_e.instr, exp_e.addr);
        else chk_pass++;
      end
      if (hs_model != 16'hFFFF) hs_model = hs_model + 16'd1;
    end
  end

  task automatic alloc_addr(input logic load, input logic [11:0] base, output logic [11:0] a);
    a = load ? {base[11:2], 2'b00} : next_addr;
    next_addr = a + 12'd4;
  endtask

  // Starts and ends on a falling edge; holds the request until accepted.
  task automatic send(input logic [8:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, input logic [31:0] exp_instr,
                      input logic expect_emit, input logic load, input logic [11:0] base);
    logic [11:0] a;
    sb_t         e;
    int          n;
    if (expect_emit) begin
      alloc_addr(load, base, a);
      e.instr = exp_instr;
      e.addr  = a;
      sb_q.push_back(e);
    end else if (load) begin
      next_addr = {base[11:2], 2'b00};
    end
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_rd    = rd;
    bus.req_rs1   = rs1;
    bus.req_rs2   = rs2;
    bus.req_imm   = imm;
    addr_load     = load;
    addr_base     = base;
    #1;
    n = 0;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.req_ready) begin
      chk_total++;
      $display("FAIL accept_timeout: req_ready=%b, required 1", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    addr_load     = 1'b0;
  endtask

  task automatic drain();
    int n;
    bus.out_ready = 1'b1;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk_total++;
    if (sb_q.size() != 0) $display("FAIL drain: %0d words outstanding, required 0", sb_q.size());
    else chk_pass++;
    chk_total++;
    if (word_count !== hs_model) $display("FAIL word_count: got %0d, required %0d", word_count, hs_model);
    else chk_pass++;
  endtask

  task automatic load_addr(input logic [11:0] base);
    addr_load = 1'b1;
    addr_base = base;
    @(negedge clk);
    addr_load = 1'b0;
    next_addr = {base[11:2], 2'b00};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b, required 0", bus.out_valid); else chk_pass++;
    chk_total++; if (bus.out_instr !== 32'h0) $display("FAIL rst_out_instr: got %h, required 0", bus.out_instr); else chk_pass++;
    chk_total++; if (bus.out_addr !== 12'h000) $display("FAIL rst_out_addr: got %h, required 000", bus.out_addr); else chk_pass++;
    chk_total++; if (word_count !== 16'h0) $display("FAIL rst_word_count: got %h, required 0", word_count); else chk_pass++;
    chk_total++; if (err !== 1'b0) $display("FAIL rst_err: got %b, required 0", err); else chk_pass++;
    chk_total++; if (bus.req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b, required 1", bus.req_ready); else chk_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    send(9'h004, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b1, 1'b0, 12'h0);
    #1;
    chk_total++; if (bus.out_valid !== 1'b1) $display("FAIL addi_valid: got %b, required 1", bus.out_valid); else chk_pass++;
    chk_total++; if (bus.out_instr !== 32'h00500093) $display("FAIL addi_instr: got %h, required 00500093", bus.out_instr); else chk_pass++;
    chk_total++; if (bus.out_addr !== 12'h000) $display("FAIL addi_addr: got %h, required 000", bus.out_addr); else chk_pass++;
    @(negedge clk);
    drain();
  endtask

  task automatic test_back_to_back();
    int t0;
    load_addr(12'h000);
    send(9'h00C, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b1, 1'b0, 12'h0);
    t0 = cyc;
    send(9'h10C, 5'd3, 5'd1, 5'd2, 32'd0, 32'h402081B3, 1'b1, 1'b0, 12'h0);
    #1;
    chk_total++; if (cyc - t0 !== 1) $display("FAIL b2b_bubble: got %0d cycles, required 1", cyc - t0); else chk_pass++;
    chk_total++; if (bus.out_instr !== 32'h402081B3) $display("FAIL b2b_sub: got %h, required 402081B3", bus.out_instr); else chk_pass++;
    @(negedge clk);
    drain();
  endtask

  task automatic test_formats();
    send(9'h00D, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b1, 1'b0, 12'h0);
    send(9'h018, 5'd0, 5'd1, 5'd2, 32'd8, 32'h00208463, 1'b1, 1'b0, 12'h0);
    send(9'h01B, 5'd1, 5'd0, 5'd0, 32'h800, 32'h001000EF, 1'b1, 1'b0, 12'h0);
    send(9'h1A4, 5'd1, 5'd1, 5'd0, 32'd3, 32'h4030D093, 1'b1, 1'b0, 12'h0);
    // SW with a non-zero rd that must not leak into the word
    send(9'h048, 5'h1F, 5'd2, 5'd3, 32'hFFFFFFFC, 32'hFE312E23, 1'b1, 1'b0, 12'h0);
    drain();
  endtask

  task automatic test_stall_wrap();
    logic [11:0] a;
    sb_t         e;
    load_addr(12'hFF8);
    bus.out_ready = 1'b0;
    send(9'h004, 5'd1, 5'd0, 5'd0, 32'd1, 32'h00100093, 1'b1, 1'b0, 12'h0);
    alloc_addr(1'b0, 12'h0, a);
    e.instr = 32'h00200113;
    e.addr  = a;
    sb_q.push_back(e);
    bus.req_valid = 1'b1;
    bus.req_op    = 9'h004;
    bus.req_rd    = 5'd2;
    bus.req_rs1   = 5'd0;
    bus.req_rs2   = 5'd0;
    bus.req_imm   = 32'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_total++; if (bus.req_ready !== 1'b0) $display("FAIL stall_ready: got %b, required 0", bus.req_ready); else chk_pass++;
      chk_total++; if (bus.out_instr !== 32'h00100093) $display("FAIL stall_instr: got %h, required 00100093", bus.out_instr); else chk_pass++;
      chk_total++; if (bus.out_addr !== 12'hFF8) $display("FAIL stall_addr: got %h, required FF8", bus.out_addr); else chk_pass++;
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    chk_total++; if (bus.req_ready !== 1'b1) $display("FAIL release_ready: got %b, required 1", bus.req_ready); else chk_pass++;
    @(negedge clk);
    bus.req_valid = 1'b0;
    send(9'h004, 5'd3, 5'd0, 5'd0, 32'd3, 32'h00300193, 1'b1, 1'b0, 12'h0);
    #1;
    chk_total++; if (bus.out_addr !== 12'h000) $display("FAIL wrap_addr: got %h, required 000", bus.out_addr); else chk_pass++;
    @(negedge clk);
    drain();
  endtask

  task automatic test_addr_load();
    send(9'h004, 5'd4, 5'd0, 5'd0, 32'd4, 32'h00400213, 1'b1, 1'b1, 12'h103);
    #1;
    chk_total++; if (bus.out_addr !== 12'h100) $display("FAIL load_addr: got %h, required 100", bus.out_addr); else chk_pass++;
    @(negedge clk);
    send(9'h004, 5'd5, 5'd0, 5'd0, 32'd5, 32'h00500293, 1'b1, 1'b0, 12'h0);
    drain();
  endtask

`ifdef RV_ENCODER_RANGE_CHECK_EN
  task automatic test_range_check();
    send(9'h004, 5'd1, 5'd0, 5'd0, 32'h800, 32'h0, 1'b0, 1'b0, 12'h0);
    #1;
    chk_total++; if (err !== 1'b1) $display("FAIL rc_err_set: got %b, required 1", err); else chk_pass++;
    chk_total++; if (bus.out_valid !== 1'b0) $display("FAIL rc_no_emit: got %b, required 0", bus.out_valid); else chk_pass++;
    chk_total++; if (word_count !== hs_model) $display("FAIL rc_count: got %0d, required %0d", word_count, hs_model); else chk_pass++;
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    chk_total++; if (err !== 1'b0) $display("FAIL rc_err_clr: got %b, required 0", err); else chk_pass++;
    @(negedge clk);
    err_clr = 1'b1;
    send(9'h01F, 5'd1, 5'd1, 5'd1, 32'h0, 32'h0, 1'b0, 1'b0, 12'h0);
    err_clr = 1'b0;
    #1;
    chk_total++; if (err !== 1'b1) $display("FAIL rc_err_vs_clr: got %b, required 1", err); else chk_pass++;
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    send(9'h018, 5'd0, 5'd1, 5'd2, 32'd9, 32'h0, 1'b0, 1'b0, 12'h0);
    send(9'h00D, 5'd5, 5'd0, 5'd0, 32'h12345001, 32'h0, 1'b0, 1'b0, 12'h0);
    send(9'h024, 5'd1, 5'd1, 5'd0, 32'd32, 32'h0, 1'b0, 1'b0, 12'h0);
    // valid word after errors lands on the unadvanced address
    send(9'h004, 5'd1, 5'd0, 5'd0, 32'hFFFFF800, 32'h80000093, 1'b1, 1'b0, 12'h0);
    drain();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask
`else
  task automatic test_truncate();
    send(9'h004, 5'd1, 5'd0, 5'd0, 32'h800, 32'h80000093, 1'b1, 1'b0, 12'h0);
    send(9'h00D, 5'd5, 5'd0, 5'd0, 32'h12345FFF, 32'h123452B7, 1'b1, 1'b0, 12'h0);
    send(9'h01F, 5'd1, 5'd1, 5'd1, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 12'h0);
    drain();
    chk_total++; if (err !== 1'b0) $display("FAIL trunc_err: got %b, required 0", err); else chk_pass++;
  endtask
`endif

  task automatic test_reset_midstream();
    bus.out_ready = 1'b0;
    send(9'h004, 5'd7, 5'd0, 5'd0, 32'd7, 32'h0, 1'b0, 1'b0, 12'h0);
    rst_n = 1'b0;
    #1;
    chk_total++; if (bus.out_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b, required 0", bus.out_valid); else chk_pass++;
    chk_total++; if (word_count !== 16'h0) $display("FAIL mid_rst_count: got %0d, required 0", word_count); else chk_pass++;
    next_addr = 12'h000;
    hs_model  = 16'h0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    send(9'h004, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b1, 1'b0, 12'h0);
    drain();
  endtask

  initial begin
    chk_total     = 0;
    chk_pass      = 0;
    cyc           = 0;
    next_addr     = 12'h000;
    hs_model      = 16'h0;
    rst_n         = 1'b0;
    addr_load     = 1'b0;
    addr_base     = 12'h0;
    err_clr       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = 9'h0;
    bus.req_rd    = 5'd0;
    bus.req_rs1   = 5'd0;
    bus.req_rs2   = 5'd0;
    bus.req_imm   = 32'h0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_formats();
    test_stall_wrap();
    test_addr_load();
`ifdef RV_ENCODER_RANGE_CHECK_EN
    test_range_check();
`else
    test_truncate();
`endif
    test_reset_midstream();
    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end
endmodule
`default_nettype wire
